// File: rtl/gat_pkg.sv
// Shared definitions for the GAT BRAM host bridge: FSM state encoding and
// the bit layout of the status word.
package gat_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } gat_state_e;

    // status = {err_misalign[NUM_CH], ch_done[NUM_CH], state[1:0]}, LSB-packed
    localparam int STATUS_STATE_LSB = 0;
    localparam int STATUS_STATE_W   = 2;
    localparam int STATUS_DONE_LSB  = STATUS_STATE_LSB + STATUS_STATE_W;
    localparam int STATUS_W         = 32;

    // err_misalign sits directly above the per-channel done bits
    function automatic int status_err_lsb(input int num_ch);
        return STATUS_DONE_LSB + num_ch;
    endfunction

endpackage

// File: rtl/gat_load_channel.sv
// One host-loaded BRAM channel: drops misaligned writes (sticky error),
// forwards aligned writes word-addressed one cycle later, and counts them
// against the configured length to raise a sticky done flag.
module gat_load_channel #(
    parameter int DATA_W      = 32,
    parameter int BYTE_ADDR_W = 20,
    parameter int LEN_W       = 18
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   start,
    input  logic                   load_en,
    input  logic [LEN_W-1:0]       cfg_len,
    input  logic                   wr_en,
    input  logic [BYTE_ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0]      wr_data,
    output logic                   core_wr_en,
    output logic [BYTE_ADDR_W-3:0] core_wr_addr,
    output logic [DATA_W-1:0]      core_wr_data,
    output logic                   ch_done,
    output logic                   err_misalign
);

    logic             aligned;
    logic             accept;
    logic             misalign;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] cnt_inc;

    assign aligned  = (wr_addr[1:0] == 2'b00);
    assign accept   = load_en & wr_en & aligned;
    assign misalign = load_en & wr_en & ~aligned;
    // saturate instead of wrapping so late writes never fake a fresh count
    assign cnt_inc  = (&cnt) ? cnt : cnt + LEN_W'(1);

    // registered word-addressed forward of every accepted write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_wr_en   <= 1'b0;
            core_wr_addr <= '0;
            core_wr_data <= '0;
        end else begin
            core_wr_en <= accept;
            if (accept) begin
                core_wr_addr <= wr_addr[BYTE_ADDR_W-1:2];
                core_wr_data <= wr_data;
            end
        end
    end

    // write counter with sticky done; a zero length is done at start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            ch_done <= 1'b0;
        end else if (clear) begin
            cnt     <= '0;
            ch_done <= 1'b0;
        end else if (start) begin
            cnt     <= '0;
            ch_done <= (cfg_len == '0);
        end else if (accept) begin
            cnt <= cnt_inc;
            if (cnt_inc == cfg_len) ch_done <= 1'b1;
        end
    end

    // sticky misalignment flag, only host_clear or reset drops it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        err_misalign <= 1'b0;
        else if (clear)    err_misalign <= 1'b0;
        else if (misalign) err_misalign <= 1'b1;
    end

endmodule

// File: rtl/gat_bram_host_bridge.sv
// Host-side bridge for the GAT core: sequences IDLE/LOAD/RUN/DONE, loads the
// per-channel BRAMs from host writes, starts the core, times the run, and
// passes host reads through to the core BRAM with a fixed-latency qualifier.
module gat_bram_host_bridge
    import gat_pkg::*;
#(
    parameter int NUM_CH      = 3,
    parameter int DATA_W      = 32,
    parameter int BYTE_ADDR_W = 20,
    parameter int LEN_W       = 18,
    parameter int RD_LAT      = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            host_start,
    input  logic                            host_clear,
    input  logic                            host_layer,
    input  logic [NUM_CH*LEN_W-1:0]         cfg_len,
    input  logic [NUM_CH-1:0]               host_wr_en,
    input  logic [NUM_CH*BYTE_ADDR_W-1:0]   host_wr_addr,
    input  logic [NUM_CH*DATA_W-1:0]        host_wr_data,
    output logic [NUM_CH-1:0]               core_wr_en,
    output logic [NUM_CH*(BYTE_ADDR_W-2)-1:0] core_wr_addr,
    output logic [NUM_CH*DATA_W-1:0]        core_wr_data,
    output logic                            core_start,
    output logic                            core_layer,
    input  logic                            core_ready,
    input  logic                            host_rd_en,
    input  logic [BYTE_ADDR_W-1:0]          host_rd_addr,
    output logic [BYTE_ADDR_W-3:0]          core_rd_addr,
    input  logic [DATA_W-1:0]               core_rd_data,
    output logic [DATA_W-1:0]               host_rd_data,
    output logic                            host_rd_valid,
    output logic                            gat_ready,
    output logic [31:0]                     status,
    output logic [31:0]                     run_cycles
);

    localparam int WORD_W  = BYTE_ADDR_W - 2;
    localparam int ERR_LSB = status_err_lsb(NUM_CH);

    gat_state_e          state, state_nxt;
    logic                core_start_nxt;
    logic                start_acc;
    logic                load_en;
    logic [NUM_CH-1:0]   ch_done;
    logic [NUM_CH-1:0]   err_misalign;
    logic [RD_LAT:1]     vld_pipe;
    logic                rd_addr_unused;

    // clear always wins, and start is only honoured from IDLE
    assign start_acc = (state == ST_IDLE) & host_start & ~host_clear;
    assign load_en   = (state == ST_LOAD) & ~host_clear;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        gat_load_channel #(
            .DATA_W      (DATA_W),
            .BYTE_ADDR_W (BYTE_ADDR_W),
            .LEN_W       (LEN_W)
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .clear        (host_clear),
            .start        (start_acc),
            .load_en      (load_en),
            .cfg_len      (cfg_len[ch*LEN_W +: LEN_W]),
            .wr_en        (host_wr_en[ch]),
            .wr_addr      (host_wr_addr[ch*BYTE_ADDR_W +: BYTE_ADDR_W]),
            .wr_data      (host_wr_data[ch*DATA_W +: DATA_W]),
            .core_wr_en   (core_wr_en[ch]),
            .core_wr_addr (core_wr_addr[ch*WORD_W +: WORD_W]),
            .core_wr_data (core_wr_data[ch*DATA_W +: DATA_W]),
            .ch_done      (ch_done[ch]),
            .err_misalign (err_misalign[ch])
        );
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // next-state logic; the LOAD->RUN transition requests the core start pulse
    always_comb begin
        state_nxt      = state;
        core_start_nxt = 1'b0;
        if (host_clear) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (host_start) state_nxt = ST_LOAD;
                ST_LOAD: if (&ch_done) begin
                    state_nxt      = ST_RUN;
                    core_start_nxt = 1'b1;
                end
                ST_RUN:  if (core_ready) state_nxt = ST_DONE;
                default: state_nxt = state;
            endcase
        end
    end

    // core start pulse and layer select captured on an accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_start <= 1'b0;
            core_layer <= 1'b0;
        end else begin
            core_start <= core_start_nxt;
            if (start_acc) core_layer <= host_layer;
        end
    end

    // saturating RUN-cycle counter, restarted by an accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                    run_cycles <= '0;
        else if (start_acc)                            run_cycles <= '0;
        else if (state == ST_RUN && run_cycles != '1)  run_cycles <= run_cycles + 32'd1;
    end

    // read-valid shift register: bit k is host_rd_en delayed by k cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= host_rd_en;
            for (int i = 2; i <= RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    assign core_rd_addr   = host_rd_addr[BYTE_ADDR_W-1:2];
    assign rd_addr_unused = ^host_rd_addr[1:0];
    assign host_rd_valid  = vld_pipe[RD_LAT];
    assign host_rd_data   = host_rd_valid ? core_rd_data : '0;
    assign gat_ready      = (state == ST_DONE);

    // status word assembly, unused upper bits held at zero
    always_comb begin
        status = '0;
        status[STATUS_STATE_LSB +: STATUS_STATE_W] = state;
        status[STATUS_DONE_LSB +: NUM_CH]          = ch_done;
        status[ERR_LSB +: NUM_CH]                  = err_misalign;
    end

endmodule

// File: tb/tb_gat_bram_host_bridge.sv
// Bench for gat_bram_host_bridge: directed vector table for the load flow,
// hand sequences for run timing/clear/reset corners, and randomized load and
// read traffic checked against a behavioural model.
module tb_gat_bram_host_bridge;

    localparam int NUM_CH = 3;
    localparam int DATA_W = 32;
    localparam int BA_W   = 20;
    localparam int LEN_W  = 18;
    localparam int RD_LAT = 2;
    localparam int WA_W   = BA_W - 2;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b1;
    logic                      host_start = 0, host_clear = 0, host_layer = 0;
    logic [NUM_CH*LEN_W-1:0]   cfg_len = '0;
    logic [NUM_CH-1:0]         host_wr_en = '0;
    logic [NUM_CH*BA_W-1:0]    host_wr_addr = '0;
    logic [NUM_CH*DATA_W-1:0]  host_wr_data = '0;
    logic [NUM_CH-1:0]         core_wr_en;
    logic [NUM_CH*WA_W-1:0]    core_wr_addr;
    logic [NUM_CH*DATA_W-1:0]  core_wr_data;
    logic                      core_start, core_layer;
    logic                      core_ready = 0;
    logic                      host_rd_en = 0;
    logic [BA_W-1:0]           host_rd_addr = '0;
    logic [WA_W-1:0]           core_rd_addr;
    logic [DATA_W-1:0]         core_rd_data;
    logic [DATA_W-1:0]         host_rd_data;
    logic                      host_rd_valid, gat_ready;
    logic [31:0]               status, run_cycles;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    gat_bram_host_bridge #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .BYTE_ADDR_W(BA_W), .LEN_W(LEN_W), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .host_start(host_start), .host_clear(host_clear),
        .host_layer(host_layer), .cfg_len(cfg_len), .host_wr_en(host_wr_en),
        .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
        .core_wr_en(core_wr_en), .core_wr_addr(core_wr_addr), .core_wr_data(core_wr_data),
        .core_start(core_start), .core_layer(core_layer), .core_ready(core_ready),
        .host_rd_en(host_rd_en), .host_rd_addr(host_rd_addr), .core_rd_addr(core_rd_addr),
        .core_rd_data(core_rd_data), .host_rd_data(host_rd_data), .host_rd_valid(host_rd_valid),
        .gat_ready(gat_ready), .status(status), .run_cycles(run_cycles)
    );

    // core BRAM stand-in: contents are a fixed function of the word address
    function automatic logic [31:0] mem_word(input logic [WA_W-1:0] a);
        return 32'h5A00_0000 ^ (32'(a) * 32'h9E37_79B1);
    endfunction

    logic [31:0] bram_p1 = '0, bram_p2 = '0;
    always @(posedge clk) begin
        bram_p1 <= mem_word(core_rd_addr);
        bram_p2 <= bram_p1;
    end
    assign core_rd_data = bram_p2;

    function automatic logic [31:0] st_word(input logic [2:0] e, input logic [2:0] d, input logic [1:0] s);
        return {24'd0, e, d, s};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_len(input int l0, input int l1, input int l2);
        cfg_len = {LEN_W'(l2), LEN_W'(l1), LEN_W'(l0)};
    endtask

    task automatic pulse_start();
        host_start = 1'b1; step(); host_start = 1'b0;
    endtask

    task automatic pulse_clear();
        host_clear = 1'b1; step(); host_clear = 1'b0;
    endtask

    typedef struct {
        logic [2:0]      wr_en;
        logic [BA_W-1:0] addr;
        logic [2:0]      exp_wen;
        logic [WA_W-1:0] exp_waddr;
        logic [2:0]      exp_done;
        logic [2:0]      exp_err;
        logic [1:0]      exp_st;
    } vec_t;

    vec_t vt[7];

    task automatic run_vec(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            host_wr_en = vt[i].wr_en;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                host_wr_addr[ch*BA_W +: BA_W]     = vt[i].addr;
                host_wr_data[ch*DATA_W +: DATA_W] = {8'(i), 8'(ch), 16'hBEEF};
            end
            step();
            chk($sformatf("v%0d_wr_en", i), 64'(core_wr_en), 64'(vt[i].exp_wen));
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (vt[i].exp_wen[ch]) begin
                    chk($sformatf("v%0d_wr_addr%0d", i, ch), 64'(core_wr_addr[ch*WA_W +: WA_W]), 64'(vt[i].exp_waddr));
                    chk($sformatf("v%0d_wr_data%0d", i, ch), 64'(core_wr_data[ch*DATA_W +: DATA_W]),
                        64'({8'(i), 8'(ch), 16'hBEEF}));
                end
            end
            chk($sformatf("v%0d_status", i), 64'(status), 64'(st_word(vt[i].exp_err, vt[i].exp_done, vt[i].exp_st)));
        end
        host_wr_en = '0;
    endtask

    typedef struct { int due; logic [WA_W-1:0] a; } rd_t;

    initial begin
        // ch0=4, ch1=2, ch2=3: done bits fill in as ch1, ch2, ch0
        vt[0] = '{3'b111, 20'h00000, 3'b111, 18'd0, 3'b000, 3'b000, 2'd1};
        vt[1] = '{3'b111, 20'h00004, 3'b111, 18'd1, 3'b010, 3'b000, 2'd1};
        vt[2] = '{3'b111, 20'h00008, 3'b111, 18'd2, 3'b110, 3'b000, 2'd1};
        vt[3] = '{3'b111, 20'h0000C, 3'b111, 18'd3, 3'b111, 3'b000, 2'd1};
        // ch0=1, ch1=2, ch2=1: misaligned ch1 write is dropped and not counted
        vt[4] = '{3'b010, 20'h00006, 3'b000, 18'd0, 3'b000, 3'b010, 2'd1};
        vt[5] = '{3'b111, 20'h00020, 3'b111, 18'd8, 3'b101, 3'b010, 2'd1};
        vt[6] = '{3'b010, 20'h00024, 3'b010, 18'd9, 3'b111, 3'b010, 2'd1};

        // reset state
        #1 rst_n = 1'b0;
        #2;
        chk("rst_status", 64'(status), 64'd0);
        chk("rst_run_cycles", 64'(run_cycles), 64'd0);
        chk("rst_gat_ready", 64'(gat_ready), 64'd0);
        chk("rst_core_start", 64'(core_start), 64'd0);
        chk("rst_core_layer", 64'(core_layer), 64'd0);
        chk("rst_core_wr_en", 64'(core_wr_en), 64'd0);
        chk("rst_rd_valid", 64'(host_rd_valid), 64'd0);
        chk("rst_rd_data", 64'(host_rd_data), 64'd0);
        step(); step();
        rst_n = 1'b1;
        step();

        // load, start and run timing
        set_len(4, 2, 3);
        host_layer = 1'b1;
        pulse_start();
        host_layer = 1'b0;
        chk("s1_status_load", 64'(status), 64'(st_word(3'b000, 3'b000, 2'd1)));
        chk("s1_core_layer", 64'(core_layer), 64'd1);
        run_vec(0, 3);
        step();
        chk("s1_status_run", 64'(status), 64'(st_word(3'b000, 3'b111, 2'd2)));
        chk("s1_core_start_hi", 64'(core_start), 64'd1);
        step();
        chk("s1_core_start_lo", 64'(core_start), 64'd0);
        chk("s1_run_cycles_1", 64'(run_cycles), 64'd1);
        repeat (8) step();
        core_ready = 1'b1;
        step();
        chk("s1_run_cycles_10", 64'(run_cycles), 64'd10);
        chk("s1_gat_ready", 64'(gat_ready), 64'd1);
        chk("s1_status_done", 64'(status), 64'(st_word(3'b000, 3'b111, 2'd3)));
        pulse_start();
        chk("s1_start_ignored", 64'(status), 64'(st_word(3'b000, 3'b111, 2'd3)));
        chk("s1_run_cycles_hold", 64'(run_cycles), 64'd10);
        core_ready = 1'b0;
        pulse_clear();
        chk("s1_clear_status", 64'(status), 64'd0);
        chk("s1_clear_gat_ready", 64'(gat_ready), 64'd0);

        // misaligned write
        set_len(1, 2, 1);
        pulse_start();
        run_vec(4, 6);
        step();
        chk("s2_status_run", 64'(status), 64'(st_word(3'b010, 3'b111, 2'd2)));
        chk("s2_core_start", 64'(core_start), 64'd1);
        pulse_clear();
        chk("s2_clear_err", 64'(status), 64'd0);

        // clear beats a simultaneous start
        host_start = 1'b1; host_clear = 1'b1;
        step();
        host_start = 1'b0; host_clear = 1'b0;
        chk("s3_start_clear", 64'(status), 64'd0);
        step();
        chk("s3_still_idle", 64'(status), 64'd0);

        // zero lengths: one LOAD cycle then a single core_start
        set_len(0, 0, 0);
        pulse_start();
        chk("s4_status_load", 64'(status), 64'(st_word(3'b000, 3'b111, 2'd1)));
        chk("s4_run_cycles_clr", 64'(run_cycles), 64'd0);
        step();
        chk("s4_status_run", 64'(status), 64'(st_word(3'b000, 3'b111, 2'd2)));
        chk("s4_core_start_hi", 64'(core_start), 64'd1);
        step();
        chk("s4_core_start_lo", 64'(core_start), 64'd0);
        pulse_clear();

        // asynchronous reset in LOAD
        set_len(4, 2, 3);
        pulse_start();
        host_wr_en = 3'b011;
        host_wr_addr = {20'h0, 20'h0, 20'h2};
        step();
        host_wr_en = '0;
        chk("s5_status_pre", 64'(status), 64'(st_word(3'b001, 3'b000, 2'd1)));
        #2 rst_n = 1'b0;
        #1;
        chk("s5_rst_status", 64'(status), 64'd0);
        chk("s5_rst_wr_en", 64'(core_wr_en), 64'd0);
        step();
        rst_n = 1'b1;
        repeat (3) step();
        chk("s5_idle_after_rst", 64'(status), 64'd0);

        // randomized load against a model of counts, done and sticky errors
        for (int it = 0; it < 4; it++) begin
            int             len[NUM_CH];
            int             cnt[NUM_CH];
            logic [2:0]     m_done, m_err, acc, mis;
            logic [1:0]     m_st;
            logic           pulse, reached;
            logic [BA_W-1:0] ra[NUM_CH];
            logic [31:0]    rdat[NUM_CH];
            pulse_clear();
            for (int ch = 0; ch < NUM_CH; ch++) begin
                len[ch] = int'($urandom_range(0, 5));
                cnt[ch] = 0;
                m_done[ch] = (len[ch] == 0);
            end
            set_len(len[0], len[1], len[2]);
            m_err = '0;
            m_st = 2'd1;
            pulse_start();
            chk($sformatf("r%0d_status_load", it), 64'(status), 64'(st_word(m_err, m_done, m_st)));
            reached = 1'b0;
            for (int c = 0; c < 200 && !reached; c++) begin
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    host_wr_en[ch] = ($urandom_range(0, 3) != 0);
                    ra[ch] = {$urandom_range(0, 2**16 - 1), 2'b00, ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00};
                    rdat[ch] = $urandom;
                    host_wr_addr[ch*BA_W +: BA_W] = ra[ch];
                    host_wr_data[ch*DATA_W +: DATA_W] = rdat[ch];
                    acc[ch] = (m_st == 2'd1) && host_wr_en[ch] && (ra[ch][1:0] == 2'b00);
                    mis[ch] = (m_st == 2'd1) && host_wr_en[ch] && (ra[ch][1:0] != 2'b00);
                end
                pulse = (m_st == 2'd1) && (&m_done);
                if (pulse) m_st = 2'd2;
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    if (acc[ch]) cnt[ch]++;
                    if (cnt[ch] >= len[ch]) m_done[ch] = 1'b1;
                    if (mis[ch]) m_err[ch] = 1'b1;
                end
                step();
                chk($sformatf("r%0d_c%0d_wr_en", it, c), 64'(core_wr_en), 64'(acc));
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    if (acc[ch]) begin
                        chk($sformatf("r%0d_c%0d_addr%0d", it, c, ch), 64'(core_wr_addr[ch*WA_W +: WA_W]), 64'(ra[ch][BA_W-1:2]));
                        chk($sformatf("r%0d_c%0d_data%0d", it, c, ch), 64'(core_wr_data[ch*DATA_W +: DATA_W]), 64'(rdat[ch]));
                    end
                end
                chk($sformatf("r%0d_c%0d_status", it, c), 64'(status), 64'(st_word(m_err, m_done, m_st)));
                chk($sformatf("r%0d_c%0d_core_start", it, c), 64'(core_start), 64'(pulse));
                if (m_st == 2'd2) reached = 1'b1;
            end
            host_wr_en = '0;
            chk($sformatf("r%0d_reached_run", it), 64'(reached), 64'd1);
            core_ready = 1'b1;
            step();
            core_ready = 1'b0;
            chk($sformatf("r%0d_done", it), 64'(gat_ready), 64'd1);
        end
        pulse_clear();

        // reads: three back-to-back directed, then random traffic
        begin
            rd_t rq[$];
            for (int t = 0; t < 160; t++) begin
                @(negedge clk);
                if (t < 3) begin
                    host_rd_en = 1'b1;
                    host_rd_addr = 20'h10 + 20'(4 * t);
                end else if (t < 6 || t >= 150) begin
                    host_rd_en = 1'b0;
                end else begin
                    host_rd_en = 1'($urandom_range(0, 1));
                    host_rd_addr = 20'($urandom);
                end
                #1;
                if (host_rd_en) begin
                    rd_t r;
                    r.due = t + RD_LAT - 1;
                    r.a = host_rd_addr[BA_W-1:2];
                    chk($sformatf("rd%0d_core_addr", t), 64'(core_rd_addr), 64'(r.a));
                    rq.push_back(r);
                end
                @(posedge clk);
                #1;
                begin
                    logic exp_v;
                    exp_v = (rq.size() > 0) && (rq[0].due == t);
                    chk($sformatf("rd%0d_valid", t), 64'(host_rd_valid), 64'(exp_v));
                    if (exp_v) begin
                        chk($sformatf("rd%0d_data", t), 64'(host_rd_data), 64'(mem_word(rq[0].a)));
                        void'(rq.pop_front());
                    end
                end
            end
            chk("rd_queue_drained", 64'(rq.size()), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/gat_bram_host_bridge.md
GAT_BRAM_HOST_BRIDGE -- requirements
Module: gat_bram_host_bridge

Interface
REQ-001 Parameter NUM_CH, default 3, meaning the number of host-loaded BRAM channels (h_data, node_info, wgt).
REQ-002 Parameter DATA_W, default 32, meaning the write/read data width per channel.
REQ-003 Parameter BYTE_ADDR_W, default 20, meaning the host byte-address width; the word address is BYTE_ADDR_W-2 bits wide.
REQ-004 Parameter LEN_W, default 18, meaning the width of the per-channel expected word count.
REQ-005 Parameter RD_LAT, default 2, range 1..4, meaning the core BRAM read latency in cycles.
REQ-006 clk  in  1  single clock; reset is asynchronous and active-low via rst_n.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 host_start  in  1  one-cycle pulse that begins a load/run sequence.
REQ-009 host_clear  in  1  one-cycle pulse that returns the block to IDLE.
REQ-010 host_layer  in  1  layer select, captured on accepted host_start.
REQ-011 cfg_len  in  NUM_CH*LEN_W  expected word count per channel.
REQ-012 host_wr_en  in  NUM_CH  per-channel write strobe.
REQ-013 host_wr_addr  in  NUM_CH*BYTE_ADDR_W  per-channel byte address.
REQ-014 host_wr_data  in  NUM_CH*DATA_W  per-channel write data.
REQ-015 core_wr_en / core_wr_addr / core_wr_data  out  NUM_CH / NUM_CH*(BYTE_ADDR_W-2) / NUM_CH*DATA_W  registered word-addressed write to the core BRAMs.
REQ-016 core_start  out  1  one-cycle start pulse to the core.
REQ-017 core_layer  out  1  captured layer select.
REQ-018 core_ready  in  1  core completion level.
REQ-019 host_rd_en  in  1  read request; host_rd_addr  in  BYTE_ADDR_W  byte address.
REQ-020 core_rd_addr  out  BYTE_ADDR_W-2  word address; core_rd_data  in  DATA_W  core BRAM data.
REQ-021 host_rd_data  out  DATA_W  read data; host_rd_valid  out  1  read data qualifier.
REQ-022 gat_ready  out  1  high in DONE; status  out  32  {err_misalign[NUM_CH], ch_done[NUM_CH], state[1:0]} LSB-packed, upper bits zero.
REQ-023 run_cycles  out  32  number of cycles spent in RUN.

Function
REQ-024 The FSM SHALL have states IDLE(0), LOAD(1), RUN(2) and DONE(3).
REQ-025 IDLE->LOAD on host_start; LOAD->RUN when all ch_done are set, with core_start pulsed on that transition; RUN->DONE when core_ready=1; host_clear from any state ->IDLE, and host_clear wins over a simultaneous host_start.
REQ-026 host_start outside IDLE SHALL be ignored.
REQ-027 Writes SHALL be accepted only in LOAD, with byte address bits [1:0]==0; core_wr_* SHALL equal the accepted write, with address = byte address[BYTE_ADDR_W-1:2], exactly 1 cycle later.
REQ-028 A misaligned write SHALL be dropped and SHALL set sticky err_misalign[ch]; err_misalign clears only on host_clear or reset.
REQ-029 A per-channel counter SHALL increment on each accepted write; ch_done[ch] SHALL set when the counter equals cfg_len[ch], and a channel with cfg_len=0 SHALL be done immediately.
REQ-030 Writes arriving after ch_done SHALL still be forwarded, and the counter SHALL saturate at its maximum value without wrapping.
REQ-031 Reads SHALL be allowed in any state: core_rd_addr = host_rd_addr[BYTE_ADDR_W-1:2] combinationally, and host_rd_valid SHALL assert exactly RD_LAT cycles after host_rd_en, using a shift-register pipeline so back-to-back reads are supported.
REQ-032 run_cycles SHALL increment each cycle in RUN, hold in DONE, clear on host_start, and saturate at 0xFFFFFFFF.
REQ-033 Reset values: all outputs 0; state IDLE.

Reset
REQ-034 rst_n low SHALL asynchronously clear the FSM, counters, done and err flags, and the read pipeline; the sequence SHALL resume only on a new host_start after release.

Structure
REQ-035 State encoding and status bit offsets SHALL reside in shared package gat_pkg.
REQ-036 A per-channel sub-module gat_load_channel (alignment check, address shift, counter, done/err flags) SHALL be instantiated NUM_CH times.

Verification
REQ-037 cfg_len={4,2,3}, host_start, aligned writes to 0x0,0x4,0x8,0xC -> core_wr_addr 0,1,2,3; ch_done=0b111 after the last write; core_start pulses once; state=RUN.
REQ-038 Write to 0x6 on ch1 in LOAD -> no core_wr_en; status err_misalign[1]=1; count unchanged.
REQ-039 In RUN, core_ready raised after 10 cycles -> run_cycles=10, gat_ready=1, state=DONE.
REQ-040 RD_LAT=2, host_rd_en on 3 consecutive cycles at 0x10,0x14,0x18 -> core_rd_addr 4,5,6; host_rd_valid high on cycles 2,3,4 with matching data.
REQ-041 host_start and host_clear asserted in the same cycle in IDLE -> remain in IDLE; rst_n pulsed low in LOAD -> all flags 0 and state IDLE.
REQ-042 cfg_len={0,0,0}, host_start -> LOAD for one cycle, then RUN with a single core_start pulse.
